// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scancode tracker: prefix and controller
// error byte values, the parser state encoding, the Pause sequence length,
// and small byte-classification helpers.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef logic [7:0] scancode_t;

    localparam scancode_t CODE_E0     = 8'hE0;  // extended-key prefix
    localparam scancode_t CODE_F0     = 8'hF0;  // break (release) prefix
    localparam scancode_t CODE_E1     = 8'hE1;  // Pause sequence lead-in
    localparam scancode_t CODE_ERR_00 = 8'h00;  // controller error
    localparam scancode_t CODE_ERR_FF = 8'hFF;  // controller overrun

    // Bytes that follow E1 in the Pause make sequence (14 77 E1 F0 14 F0 77).
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP
    } parser_state_t;

    function automatic logic is_prefix(input scancode_t b);
        return (b == CODE_E0) || (b == CODE_F0) || (b == CODE_E1);
    endfunction

    function automatic logic is_error_code(input scancode_t b);
        return (b == CODE_ERR_00) || (b == CODE_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_history_buffer.sv
// ---------------------------------------------------------------------------
// ps2_history_buffer
// Shift register of the most recent DEPTH make codes with a saturating
// occupancy count. Entry 0 is the newest; a write pushes every entry one
// slot older and drops the oldest when full.
//
// Ports:
//   CLOCK_50       in   clock, rising edge
//   reset          in   synchronous active-high reset
//   wr_en          in   push one make event this cycle
//   wr_code        in   make scancode to push
//   wr_ext         in   extended flag of the pushed make
//   history_data   out  entry i at bits [8i+7:8i]
//   history_ext    out  extended flag, bit i matches entry i
//   history_count  out  valid entries, saturates at DEPTH
// ---------------------------------------------------------------------------
module ps2_history_buffer
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       wr_en,
    input  scancode_t                  wr_code,
    input  logic                       wr_ext,
    output logic [DEPTH*8-1:0]         history_data,
    output logic [DEPTH-1:0]           history_ext,
    output logic [$clog2(DEPTH+1)-1:0] history_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            // NOTE: this history is a handful of flops, not a RAM, so it is
            // cleared on reset; stale codes must never read back as valid.
            history_data  <= '0;
            history_ext   <= '0;
            history_count <= '0;
        end else if (wr_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                history_data[8*i +: 8] <= history_data[8*(i-1) +: 8];
                history_ext[i]         <= history_ext[i-1];
            end
            history_data[7:0] <= wr_code;
            history_ext[0]    <= wr_ext;
            if (history_count != COUNT_FULL) begin
                history_count <= history_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_tracker.sv
// ---------------------------------------------------------------------------
// ps2_scancode_tracker
// Decodes PS/2 set-2 scancode bytes into key events (make/release, extended),
// discards the Pause sequence, abandons stale prefixes after a timeout,
// optionally suppresses typematic repeats, and logs reported makes into a
// history buffer.
//
// Ports:
//   CLOCK_50          in   clock, rising edge
//   reset             in   synchronous active-high reset
//   received_data     in   byte from the PS/2 controller
//   received_data_en  in   one-cycle strobe qualifying received_data
//   event_valid       out  one-cycle pulse per decoded event
//   event_code        out  scancode of the last event, prefixes stripped
//   event_extended    out  last event carried an E0 prefix
//   event_release     out  last event carried an F0 prefix
//   history_data      out  logged make codes, entry 0 newest
//   history_ext       out  extended flag per history entry
//   history_count     out  valid history entries, saturates at DEPTH
// ---------------------------------------------------------------------------
module ps2_scancode_tracker
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit FILTER_REPEAT  = 1'b1
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [7:0]                 received_data,
    input  logic                       received_data_en,
    output logic                       event_valid,
    output logic [7:0]                 event_code,
    output logic                       event_extended,
    output logic                       event_release,
    output logic [DEPTH*8-1:0]         history_data,
    output logic [DEPTH-1:0]           history_ext,
    output logic [$clog2(DEPTH+1)-1:0] history_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    parser_state_t    state, state_next;
    logic [2:0]       skip_cnt, skip_next;
    logic [TMO_W-1:0] timeout_cnt;
    logic             timeout_hit;

    logic             emit, emit_ext, emit_rel;

    scancode_t        last_make_code;
    logic             last_make_ext;
    logic             last_make_valid;
    logic             matches_last;
    logic             report;
    logic             hist_wr;

    // The counter sits one short of the limit on the cycle the limit is
    // reached, so the forced return to IDLE lands on that edge.
    assign timeout_hit = (state != IDLE) && (timeout_cnt == TMO_LAST);

    // ---------------- parser next-state / event decode ----------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        skip_next  = skip_cnt;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_rel   = 1'b0;

        if (received_data_en) begin
            // A strobe always wins over a coincident timeout expiry.
            if (is_error_code(received_data)) begin
                state_next = IDLE;
                skip_next  = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (received_data == CODE_E0) begin
                            state_next = GOT_E0;
                        end else if (received_data == CODE_F0) begin
                            state_next = GOT_F0;
                        end else if (received_data == CODE_E1) begin
                            state_next = SKIP;
                            skip_next  = PAUSE_SKIP_LEN;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    GOT_E0: begin
                        if (received_data == CODE_F0) begin
                            state_next = GOT_E0F0;
                        end else if (received_data != CODE_E0) begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    GOT_F0: begin
                        state_next = IDLE;
                        emit       = !is_prefix(received_data);
                        emit_rel   = 1'b1;
                    end
                    GOT_E0F0: begin
                        state_next = IDLE;
                        emit       = !is_prefix(received_data);
                        emit_ext   = 1'b1;
                        emit_rel   = 1'b1;
                    end
                    SKIP: begin
                        skip_next = skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        skip_next  = '0;
                    end
                endcase
            end
        end else if (timeout_hit) begin
            state_next = IDLE;
            skip_next  = '0;
        end
    end

    // ---------------- parser state and counters ----------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values, independent of statement order.
            state    <= state_next;
            skip_cnt <= skip_next;
            if (received_data_en || state == IDLE || timeout_hit) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

    // ---------------- typematic repeat filter ----------------
    assign matches_last = last_make_valid
                       && (last_make_code == received_data)
                       && (last_make_ext == emit_ext);

    assign report  = emit && (emit_rel || !(FILTER_REPEAT && matches_last));
    assign hist_wr = report && !emit_rel;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_make_code  <= '0;
            last_make_ext   <= 1'b0;
            last_make_valid <= 1'b0;
        end else if (report) begin
            if (!emit_rel) begin
                last_make_code  <= received_data;
                last_make_ext   <= emit_ext;
                last_make_valid <= 1'b1;
            end else if (matches_last) begin
                // Releasing the held key rearms reporting of its next make.
                last_make_valid <= 1'b0;
            end
        end
    end

    // ---------------- event outputs ----------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            event_valid    <= 1'b0;
            event_code     <= '0;
            event_extended <= 1'b0;
            event_release  <= 1'b0;
        end else begin
            event_valid <= report;
            if (report) begin
                event_code     <= received_data;
                event_extended <= emit_ext;
                event_release  <= emit_rel;
            end
        end
    end

    // ---------------- make history ----------------
    ps2_history_buffer #(
        .DEPTH (DEPTH)
    ) u_history (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .wr_en         (hist_wr),
        .wr_code       (received_data),
        .wr_ext        (emit_ext),
        .history_data  (history_data),
        .history_ext   (history_ext),
        .history_count (history_count)
    );

endmodule

// File: tb/tb_ps2_scancode_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_tracker
// Directed bench: byte sequences are driven on the falling edge, decoded
// events are collected into a queue on the falling edge, and each block of
// stimulus is checked against hand-computed event lists and history contents.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_tracker;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               CLOCK_50 = 1'b0;
    logic               reset;
    logic [7:0]         received_data;
    logic               received_data_en;
    logic               event_valid;
    logic [7:0]         event_code;
    logic               event_extended;
    logic               event_release;
    logic [DEPTH*8-1:0] history_data;
    logic [DEPTH-1:0]   history_ext;
    logic [CNT_W-1:0]   history_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] ev_q[$];  // {extended, release, code}

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_scancode_tracker #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_REPEAT  (1'b1)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .event_valid      (event_valid),
        .event_code       (event_code),
        .event_extended   (event_extended),
        .event_release    (event_release),
        .history_data     (history_data),
        .history_ext      (history_ext),
        .history_count    (history_count)
    );

    always @(negedge CLOCK_50) begin
        if (event_valid) begin
            ev_q.push_back({event_extended, event_release, event_code});
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [9:0] ev(input bit ext, input bit rel,
                                      input logic [7:0] code);
        return {ext, rel, code};
    endfunction

    function automatic logic [9:0] ev_at(input int i);
        return (i < ev_q.size()) ? ev_q[i] : 10'h3FF;
    endfunction

    // Called on a falling edge; the strobe covers exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        ev_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        idle(2);

        // Reset state
        check("rst_valid", event_valid, 0);
        check("rst_code", event_code, 0);
        check("rst_ext", event_extended, 0);
        check("rst_rel", event_release, 0);
        check("rst_hdata", history_data, 0);
        check("rst_hext", history_ext, 0);
        check("rst_hcount", history_count, 0);
        reset = 1'b0;
        idle(1);

        // Plain make then release
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        idle(2);
        check("mk_n", ev_q.size(), 2);
        check("mk_e0", ev_at(0), ev(0, 0, 8'h1C));
        check("mk_e1", ev_at(1), ev(0, 1, 8'h1C));
        check("mk_hist0", history_data[7:0], 8'h1C);
        check("mk_count", history_count, 1);

        // Extended make then extended release
        ev_q.delete();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        idle(2);
        check("ext_n", ev_q.size(), 2);
        check("ext_e0", ev_at(0), ev(1, 0, 8'h75));
        check("ext_e1", ev_at(1), ev(1, 1, 8'h75));
        check("ext_hext", history_ext[1:0], 2'b01);
        check("ext_hdata", history_data[15:0], 16'h1C75);
        check("ext_count", history_count, 2);
        idle(3);
        check("hold_valid", event_valid, 0);
        check("hold_code", event_code, 8'h75);
        check("hold_flags", {event_extended, event_release}, 2'b11);

        // Typematic repeat filter
        do_reset();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'h1C); send_byte(8'h1C);
        idle(2);
        check("rep_n", ev_q.size(), 3);
        check("rep_e0", ev_at(0), ev(0, 0, 8'h1C));
        check("rep_e1", ev_at(1), ev(0, 1, 8'h1C));
        check("rep_e2", ev_at(2), ev(0, 0, 8'h1C));
        check("rep_count", history_count, 2);

        // A different make rearms the filter
        ev_q.delete();
        send_byte(8'h1D); send_byte(8'h1C);
        idle(2);
        check("rearm_n", ev_q.size(), 2);
        check("rearm_count", history_count, 4);
        check("rearm_hdata", history_data, 32'h1C1C1D1C);

        // History overflow at DEPTH
        do_reset();
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
        send_byte(8'h2D); send_byte(8'h2C);
        idle(2);
        check("full_n", ev_q.size(), 5);
        check("full_hdata", history_data, 32'h1D242D2C);
        check("full_count", history_count, 4);

        // Pause sequence yields nothing, parser returns to IDLE afterwards
        ev_q.delete();
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        idle(2);
        check("pause_n", ev_q.size(), 0);
        check("pause_count", history_count, 4);
        send_byte(8'h1C);
        idle(2);
        check("post_pause_n", ev_q.size(), 1);
        check("post_pause_e0", ev_at(0), ev(0, 0, 8'h1C));
        check("post_pause_hdata", history_data, 32'h242D2C1C);

        // Timeout: exactly TMO idle cycles abandons E0
        ev_q.delete();
        send_byte(8'hE0); idle(TMO); send_byte(8'h3A);
        idle(2);
        check("tmo_n", ev_q.size(), 1);
        check("tmo_e0", ev_at(0), ev(0, 0, 8'h3A));

        // Byte lands on the expiry cycle: byte wins, prefix still applies
        ev_q.delete();
        send_byte(8'hE0); idle(TMO - 1); send_byte(8'h4B);
        idle(2);
        check("tmo_edge_n", ev_q.size(), 1);
        check("tmo_edge_e0", ev_at(0), ev(1, 0, 8'h4B));

        // Timeout out of GOT_F0
        ev_q.delete();
        send_byte(8'hF0); idle(TMO); send_byte(8'h5C);
        idle(2);
        check("tmo_f0_e0", ev_at(0), ev(0, 0, 8'h5C));

        // Error codes and prefix protocol errors drop the partial sequence
        ev_q.delete();
        send_byte(8'hF0); send_byte(8'hFF); send_byte(8'h5A);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h12);
        idle(2);
        check("err_n", ev_q.size(), 3);
        check("err_e0", ev_at(0), ev(0, 0, 8'h5A));
        check("err_e1", ev_at(1), ev(0, 0, 8'h6B));
        check("err_e2", ev_at(2), ev(0, 0, 8'h12));

        // Reset one cycle after F0, with a strobe coincident with reset
        ev_q.delete();
        send_byte(8'hF0);
        reset            = 1'b1;
        received_data    = 8'h33;
        received_data_en = 1'b1;
        idle(1);
        check("mid_rst_valid", event_valid, 0);
        check("mid_rst_code", event_code, 0);
        check("mid_rst_flags", {event_extended, event_release}, 0);
        check("mid_rst_hdata", history_data, 0);
        check("mid_rst_count", history_count, 0);
        received_data_en = 1'b0;
        idle(1);
        reset = 1'b0;
        send_byte(8'h1C);
        idle(2);
        check("after_rst_n", ev_q.size(), 1);
        check("after_rst_e0", ev_at(0), ev(0, 0, 8'h1C));
        check("after_rst_count", history_count, 1);
        check("after_rst_hdata", history_data, 32'h0000001C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
